// File: rtl/uart_cmd_ctrl_if.sv
// UART-side handshake bundle for uart_cmd_ctrl: the received byte strobe and the ACK transmit handshake.
interface uart_cmd_ctrl_if;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output rx_byte, output rx_valid, input tx_byte, input tx_valid, output tx_ready);
    modport slave  (input rx_byte, input rx_valid, output tx_byte, output tx_valid, input tx_ready);
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Collects 5-byte UART command frames (HDR CMD ARG_H ARG_L CHK) and applies them to the ADC config.
// Optional ACK byte back to the UART when UART_CMD_ACK_EN is defined.
module uart_cmd_ctrl #(
    parameter int          TIMEOUT_CYC = 50000,
    parameter logic [15:0] DIV_RST     = 16'd100,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
    input  logic              RST_clk,
    input  logic              RST,
    uart_cmd_ctrl_if.slave    bus,
    output logic              adc_run,
    output logic [15:0]       adc_div,
    output logic [2:0]        adc_ch,
    output logic              cmd_ok,
    output logic              cmd_err,
    output logic [2:0]        err_code
);
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);

`ifdef UART_CMD_ACK_EN
    typedef enum logic [2:0] {IDLE, S_CMD, S_ARGH, S_ARGL, S_CHK, S_ACK} state_t;
`else
    typedef enum logic [2:0] {IDLE, S_CMD, S_ARGH, S_ARGL, S_CHK} state_t;
`endif

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d, argh_q, argh_d, argl_q, argl_d;
    logic          run_q, run_d;
    logic [15:0]   div_q, div_d;
    logic [2:0]    ch_q, ch_d;
    logic          ok_q, ok_d, err_q, err_d;
    logic [2:0]    code_q, code_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   arg_w;
    logic          timeout_w;
`ifdef UART_CMD_ACK_EN
    logic          txv_q, txv_d;
    logic [7:0]    txb_q, txb_d;
`endif

    assign arg_w = {argh_q, argl_q};

    // The ACK state is exempt: the host is waiting on us, not the other way round.
`ifdef UART_CMD_ACK_EN
    assign timeout_w = !bus.rx_valid && state_q != IDLE && state_q != S_ACK && cnt_q == TO_LAST;
`else
    assign timeout_w = !bus.rx_valid && state_q != IDLE && cnt_q == TO_LAST;
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        argh_d  = argh_q;
        argl_d  = argl_q;
        run_d   = run_q;
        div_d   = div_q;
        ch_d    = ch_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
`ifdef UART_CMD_ACK_EN
        txv_d   = txv_q;
        txb_d   = txb_q;
`endif
        if (bus.rx_valid || state_q == IDLE) cnt_d = '0;
        else                                 cnt_d = cnt_q + CW'(1);

        case (state_q)
            IDLE:   if (bus.rx_valid && bus.rx_byte == HDR_BYTE) state_d = S_CMD;
            S_CMD:  if (bus.rx_valid) begin cmd_d  = bus.rx_byte; state_d = S_ARGH; end
            S_ARGH: if (bus.rx_valid) begin argh_d = bus.rx_byte; state_d = S_ARGL; end
            S_ARGL: if (bus.rx_valid) begin argl_d = bus.rx_byte; state_d = S_CHK;  end
            S_CHK: if (bus.rx_valid) begin
                if (bus.rx_byte != (cmd_q ^ argh_q ^ argl_q)) begin
                    err_d  = 1'b1;
                    code_d = 3'd1;
                end else begin
                    ok_d = 1'b1;
                    case (cmd_q)
                        8'h01:   run_d = 1'b1;
                        8'h02:   run_d = 1'b0;
                        8'h03:   div_d = (arg_w == 16'd0) ? 16'd1 : arg_w;
                        8'h04:   ch_d  = argl_q[2:0];
                        default: begin ok_d = 1'b0; err_d = 1'b1; code_d = 3'd3; end
                    endcase
                end
`ifdef UART_CMD_ACK_EN
                state_d = S_ACK;
                txv_d   = 1'b1;
                txb_d   = ok_d ? 8'h06 : 8'h15;
`else
                state_d = IDLE;
`endif
            end
`ifdef UART_CMD_ACK_EN
            S_ACK: begin
                if (bus.rx_valid) begin
                    err_d  = 1'b1;
                    code_d = 3'd4;
                end
                if (bus.tx_ready) begin
                    txv_d   = 1'b0;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (timeout_w) begin
            state_d = IDLE;
            err_d   = 1'b1;
            code_d  = 3'd2;
        end
    end

    always_ff @(posedge RST_clk or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            argh_q  <= '0;
            argl_q  <= '0;
            run_q   <= 1'b0;
            div_q   <= DIV_RST;
            ch_q    <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            cnt_q   <= '0;
`ifdef UART_CMD_ACK_EN
            txv_q   <= 1'b0;
            txb_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            argh_q  <= argh_d;
            argl_q  <= argl_d;
            run_q   <= run_d;
            div_q   <= div_d;
            ch_q    <= ch_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
`ifdef UART_CMD_ACK_EN
            txv_q   <= txv_d;
            txb_q   <= txb_d;
`endif
        end
    end

    assign adc_run  = run_q;
    assign adc_div  = div_q;
    assign adc_ch   = ch_q;
    assign cmd_ok   = ok_q;
    assign cmd_err  = err_q;
    assign err_code = code_q;

`ifdef UART_CMD_ACK_EN
    assign bus.tx_valid = txv_q;
    assign bus.tx_byte  = txb_q;
`else
    logic unused_tx_ready;
    assign unused_tx_ready = bus.tx_ready;
    assign bus.tx_valid    = 1'b0;
    assign bus.tx_byte     = 8'h00;
`endif
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed frames against a queue-based frame model, compared every cycle, plus literal spot checks.
module tb_uart_cmd_ctrl;
    localparam int          TO   = 200;
    localparam logic [15:0] DIVR = 16'd100;
    localparam logic [7:0]  HDR  = 8'hA5;

    logic        clk = 1'b0;
    logic        rst;
    logic        adc_run, cmd_ok, cmd_err;
    logic [15:0] adc_div;
    logic [2:0]  adc_ch, err_code;
    int          checks = 0;
    int          failures = 0;

    uart_cmd_ctrl_if bus();

    uart_cmd_ctrl #(.TIMEOUT_CYC(TO), .DIV_RST(DIVR), .HDR_BYTE(HDR)) dut (
        .RST_clk(clk), .RST(rst), .bus(bus.slave),
        .adc_run(adc_run), .adc_div(adc_div), .adc_ch(adc_ch),
        .cmd_ok(cmd_ok), .cmd_err(cmd_err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Frame-level model: a byte queue per frame, decided when the fifth byte lands.
    logic [7:0]  fq[$];
    int          since;
    bit          ack_pend;
    logic        m_run, m_ok, m_err, m_txv;
    logic [15:0] m_div;
    logic [2:0]  m_ch, m_code;
    logic [7:0]  m_txb, f_c, f_h, f_l, f_k;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fq.delete(); since = 0; ack_pend = 0;
            m_run = 0; m_div = DIVR; m_ch = 0; m_code = 0;
            m_ok = 0; m_err = 0; m_txv = 0; m_txb = 0;
        end else begin
            m_ok = 0; m_err = 0;
            if (ack_pend) begin
                if (bus.rx_valid) begin m_err = 1; m_code = 4; end
                if (bus.tx_ready) begin ack_pend = 0; m_txv = 0; end
            end else if (bus.rx_valid) begin
                since = 0;
                if (fq.size() != 0 || bus.rx_byte == HDR) fq.push_back(bus.rx_byte);
                if (fq.size() == 5) begin
                    f_c = fq[1]; f_h = fq[2]; f_l = fq[3]; f_k = fq[4];
                    if (f_k != (f_c ^ f_h ^ f_l)) begin m_err = 1; m_code = 1; end
                    else if (f_c == 8'h01) begin m_ok = 1; m_run = 1; end
                    else if (f_c == 8'h02) begin m_ok = 1; m_run = 0; end
                    else if (f_c == 8'h03) begin m_ok = 1; m_div = ({f_h, f_l} == 0) ? 16'd1 : {f_h, f_l}; end
                    else if (f_c == 8'h04) begin m_ok = 1; m_ch = f_l[2:0]; end
                    else begin m_err = 1; m_code = 3; end
`ifdef UART_CMD_ACK_EN
                    ack_pend = 1; m_txv = 1; m_txb = m_ok ? 8'h06 : 8'h15;
`endif
                    fq.delete();
                end
            end else if (fq.size() != 0) begin
                if (since == TO - 1) begin
                    m_err = 1; m_code = 2; fq.delete(); since = 0;
                end else since++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("run",      adc_run,      m_run);
            chk("div",      adc_div,      m_div);
            chk("ch",       adc_ch,       m_ch);
            chk("ok",       cmd_ok,       m_ok);
            chk("err",      cmd_err,      m_err);
            chk("code",     err_code,     m_code);
            chk("tx_valid", bus.tx_valid, m_txv);
            chk("tx_byte",  bus.tx_byte,  m_txb);
            if (cmd_ok && cmd_err) chk("ok_err_excl", 1, 0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_byte = b; bus.rx_valid = 1'b1;
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic frame(input logic [7:0] b0, b1, b2, b3, b4);
        idle(2);
        send(b0); send(b1); send(b2); send(b3); send(b4);
    endtask

    initial begin
        int n;
        rst = 1; bus.rx_valid = 0; bus.rx_byte = 0; bus.tx_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_run", adc_run, 0);  chk("rst_div", adc_div, 16'd100);
        chk("rst_ch", adc_ch, 0);    chk("rst_code", err_code, 0);
        chk("rst_ok", cmd_ok, 0);    chk("rst_err", cmd_err, 0);
        rst = 0;
        idle(1);

        frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01);
        chk("t1_ok", cmd_ok, 1); chk("t1_run", adc_run, 1); chk("t1_code", err_code, 0);

        frame(8'hA5, 8'h03, 8'h12, 8'h34, 8'h25);
        chk("t2_ok", cmd_ok, 1); chk("t2_div", adc_div, 16'h1234);
        frame(8'hA5, 8'h03, 8'h12, 8'h34, 8'h27);
        chk("t2_bad_err", cmd_err, 1); chk("t2_bad_code", err_code, 1); chk("t2_bad_div", adc_div, 16'h1234);
        frame(8'hA5, 8'h03, 8'h00, 8'h00, 8'h03);
        chk("t2_div0", adc_div, 16'd1);

        frame(8'hA5, 8'h04, 8'h00, 8'h07, 8'h03);
        chk("t3_ch", adc_ch, 7);
        frame(8'hA5, 8'h04, 8'h00, 8'h07, 8'h00);
        chk("t3_err", cmd_err, 1); chk("t3_code", err_code, 1); chk("t3_ch_kept", adc_ch, 7);
        frame(8'hA5, 8'h04, 8'hA5, 8'hA5, 8'h04);
        chk("hdr_as_data_ch", adc_ch, 5);

        frame(8'hA5, 8'h09, 8'h00, 8'h00, 8'h09);
        chk("t4_err", cmd_err, 1); chk("t4_code", err_code, 3);
        idle(2);
        send(8'h3C); send(8'h5A);
        chk("t4_idle_ok", cmd_ok, 0); chk("t4_idle_err", cmd_err, 0);

        idle(2);
        send(8'hA5); send(8'h01);
        n = 0;
        while (!cmd_err && n < TO + 10) begin @(posedge clk); #1; n++; end
        chk("t5_latency", n, TO); chk("t5_code", err_code, 2); chk("t5_run_kept", adc_run, 1);
        frame(8'hA5, 8'h02, 8'h00, 8'h00, 8'h02);
        chk("t5_run", adc_run, 0);

        // byte lands exactly on the timeout cycle: no error, frame continues
        idle(2);
        send(8'hA5); send(8'h01);
        idle(TO - 1);
        send(8'h00);
        chk("tie_err", cmd_err, 0);
        send(8'h00); send(8'h01);
        chk("tie_ok", cmd_ok, 1); chk("tie_run", adc_run, 1);

        idle(2);
        send(8'hA5); send(8'h04);
        #2 rst = 1;
        #1;
        chk("mid_rst_run", adc_run, 0); chk("mid_rst_div", adc_div, 16'd100);
        chk("mid_rst_ch", adc_ch, 0);   chk("mid_rst_code", err_code, 0);
        @(posedge clk); #1 rst = 0;
        send(8'h00); send(8'h07); send(8'h03);
        chk("post_rst_ch", adc_ch, 0);

`ifdef UART_CMD_ACK_EN
        bus.tx_ready = 0;
        frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h01);
        chk("ack_ok", cmd_ok, 1); chk("ack_v", bus.tx_valid, 1); chk("ack_b", bus.tx_byte, 8'h06);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                send(8'h33);
                chk("ack_extra_err", cmd_err, 1); chk("ack_extra_code", err_code, 4);
            end else idle(1);
            chk("ack_hold_v", bus.tx_valid, 1); chk("ack_hold_b", bus.tx_byte, 8'h06);
        end
        bus.tx_ready = 1;
        idle(1);
        chk("ack_release", bus.tx_valid, 0);
        frame(8'hA5, 8'h01, 8'h00, 8'h00, 8'h00);
        chk("nak_b", bus.tx_byte, 8'h15); chk("nak_v", bus.tx_valid, 1);
        idle(3);
`else
        bus.tx_ready = 0;
        frame(8'hA5, 8'h04, 8'h00, 8'h02, 8'h06);
        chk("noack_ch", adc_ch, 2); chk("noack_v", bus.tx_valid, 0);
        idle(3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
